// File: rtl/seg_display_ctrl.sv
// Two-requester arbitrated 4-digit hex seven-segment controller.
// A granted 16-bit value is held on screen for at least HOLD_CYCLES, then scanned across the digits.
module seg_display_ctrl #(
  parameter int unsigned SCAN_DIV    = 2000,
  parameter int unsigned HOLD_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic [3:0]  AN,
  output logic [7:0]  seg,
  output logic        dbg_state
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_cnt_nxt;
  logic [15:0]         r_shown;
  logic [15:0]         w_shown_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic                r_gnt0;
  logic                w_gnt0_nxt;
  logic                r_gnt1;
  logic                w_gnt1_nxt;
  logic                w_pick1;

  logic [SCAN_W-1:0]   r_refresh;
  logic [1:0]          r_digit;
  logic [3:0]          w_nibble;
  logic [3:0]          w_an_dec;
  logic [7:0]          w_seg_dec;
  logic [3:0]          r_an;
  logic [7:0]          r_seg;

  // Handshake: a requester raises reqN with dataN stable and holds both until
  // gntN; gntN is a registered one-cycle pulse and dataN is captured on the
  // same edge that raises it. req still high the cycle after gnt is a new request.

  // Round-robin on a tie: grant whichever requester did not win last time.
  assign w_pick1 = req1 & (~req0 | ~r_last);

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_shown_nxt    = r_shown;
    w_valid_nxt    = r_valid;
    w_last_nxt     = r_last;
    w_gnt0_nxt     = 1'b0;
    w_gnt1_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_state_nxt    = HOLD;
          w_hold_cnt_nxt = '0;
          w_valid_nxt    = 1'b1;
          w_last_nxt     = w_pick1;
          if (w_pick1) begin
            w_shown_nxt = data1;
            w_gnt1_nxt  = 1'b1;
          end else begin
            w_shown_nxt = data0;
            w_gnt0_nxt  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt    = IDLE;
          w_hold_cnt_nxt = '0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_shown    <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_shown    <= w_shown_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
    end
  end

  // Scanner runs continuously so the digit phase is independent of grants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_refresh <= '0;
      r_digit   <= 2'd0;
    end else if (r_refresh == SCAN_LAST) begin
      r_refresh <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign w_nibble = r_shown[{r_digit, 2'b00} +: 4];
  assign w_an_dec = ~(4'b0001 << r_digit);

  always_comb begin
    w_seg_dec = 8'hFF;
    case (w_nibble)
      4'h0: w_seg_dec = 8'hC0;
      4'h1: w_seg_dec = 8'hF9;
      4'h2: w_seg_dec = 8'hA4;
      4'h3: w_seg_dec = 8'hB0;
      4'h4: w_seg_dec = 8'h99;
      4'h5: w_seg_dec = 8'h92;
      4'h6: w_seg_dec = 8'h82;
      4'h7: w_seg_dec = 8'hF8;
      4'h8: w_seg_dec = 8'h80;
      4'h9: w_seg_dec = 8'h90;
      4'hA: w_seg_dec = 8'h88;
      4'hB: w_seg_dec = 8'h83;
      4'hC: w_seg_dec = 8'hC6;
      4'hD: w_seg_dec = 8'hA1;
      4'hE: w_seg_dec = 8'h86;
      4'hF: w_seg_dec = 8'h8E;
      default: w_seg_dec = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || !r_valid) begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an_dec;
      r_seg <= w_seg_dec;
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign busy      = (r_state == HOLD);
  assign AN        = r_an;
  assign seg       = r_seg;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with SCAN_DIV=4, HOLD_CYCLES=8.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_seg_display_ctrl;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [15:0] data0;
  logic        req1;
  logic [15:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic [3:0]  AN;
  logic [7:0]  seg;
  logic        dbg_state;

  int errors = 0;
  int checks = 0;

  seg_display_ctrl #(.SCAN_DIV(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .AN(AN), .seg(seg), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  function automatic int an_idx(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk_disp(input string tag, input logic [15:0] val);
    int d;
    logic [3:0] nib;
    d = an_idx(AN);
    chk({tag, "_an_onehot"}, 32'(d >= 0), 32'd1);
    if (d < 0) d = 0;
    nib = val[4*d +: 4];
    chk({tag, "_seg"}, 32'(seg), 32'(hex7(nib)));
  endtask

  initial begin
    int prev_d;
    int d;
    int changes;
    logic [3:0] seen;

    reset = 1'b0; req0 = 1'b1; data0 = 16'h1234; req1 = 1'b0; data1 = 16'h0000;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_an", 32'(AN), 32'hF);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_state", 32'(dbg_state), 32'd0);
    end
    req0 = 1'b0; reset = 1'b1;
    tick();
    chk("idle_gnt0", 32'(gnt0), 32'd0);
    chk("idle_blank_an", 32'(AN), 32'hF);

    // Single request
    req0 = 1'b1; data0 = 16'h1A3F;
    tick();
    chk("sr_gnt0", 32'(gnt0), 32'd1);
    chk("sr_gnt1", 32'(gnt1), 32'd0);
    chk("sr_busy0", 32'(busy), 32'd1);
    chk("sr_state", 32'(dbg_state), 32'd1);
    req0 = 1'b0;
    seen = 4'b0000; changes = 0; prev_d = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("sr_busy", 32'(busy), 32'((1 + i) < 8));
      chk("sr_gnt0_low", 32'(gnt0), 32'd0);
      chk_disp("sr_disp", 16'h1A3F);
      d = an_idx(AN);
      if (d < 0) d = 0;
      seen[d] = 1'b1;
      if (i > 0 && d != prev_d) begin
        changes++;
        chk("sr_order", 32'(d), 32'((prev_d + 1) % 4));
      end
      prev_d = d;
    end
    chk("sr_all_digits", 32'(seen), 32'hF);
    chk("sr_scan_rate", 32'(changes == 3 || changes == 4), 32'd1);

    // Tie after reset: requester 0 first, requester 1 nine cycles later
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0 = 1'b1; data0 = 16'h0000; req1 = 1'b1; data1 = 16'hFFFF;
    tick();
    chk("tie_gnt0", 32'(gnt0), 32'd1);
    chk("tie_gnt1_first", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("tie_wait_gnt0", 32'(gnt0), 32'd0);
      chk("tie_wait_gnt1", 32'(gnt1), 32'd0);
      if (j == 1) chk_disp("tie_disp0", 16'h0000);
    end
    tick();
    chk("tie_gnt1", 32'(gnt1), 32'd1);
    chk("tie_no_double", 32'(gnt0), 32'd0);
    req1 = 1'b0;
    tick();
    chk_disp("tie_dispF", 16'hFFFF);

    // Request during HOLD
    for (int j = 0; j < 7; j++) tick();
    chk("hold_end_busy", 32'(busy), 32'd0);
    req0 = 1'b1; data0 = 16'hBEEF;
    tick();
    chk("rdh_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    tick();
    tick();
    req1 = 1'b1; data1 = 16'h5678;
    for (int j = 3; j <= 7; j++) begin
      tick();
      chk("rdh_busy", 32'(busy), 32'd1);
      chk("rdh_no_gnt1", 32'(gnt1), 32'd0);
    end
    tick();
    chk("rdh_busy_low", 32'(busy), 32'd0);
    chk("rdh_no_gnt1_idle", 32'(gnt1), 32'd0);
    tick();
    chk("rdh_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;

    // Withdrawn request during HOLD
    tick();
    req0 = 1'b1; data0 = 16'hDEAD;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("wd_gnt0_hold", 32'(gnt0), 32'd0);
    end
    req0 = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      chk("wd_gnt0", 32'(gnt0), 32'd0);
    end
    chk("wd_state", 32'(dbg_state), 32'd0);
    chk_disp("wd_disp", 16'h5678);

    // Reset four cycles into HOLD
    req0 = 1'b1; data0 = 16'h4321;
    tick();
    chk("rmh_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk("rmh_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("rmh_busy", 32'(busy), 32'd0);
    chk("rmh_state", 32'(dbg_state), 32'd0);
    chk("rmh_an", 32'(AN), 32'hF);
    chk("rmh_seg", 32'(seg), 32'hFF);
    reset = 1'b1;
    req0 = 1'b1; data0 = 16'hAAAA; req1 = 1'b1; data1 = 16'h5555;
    tick();
    chk("rmh_tie_gnt0", 32'(gnt0), 32'd1);
    chk("rmh_tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    tick();
    chk_disp("rmh_disp", 16'hAAAA);
    req1 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
